// File: rtl/demux_1to4_deser.sv
// Serial-to-parallel 1:4 deserializer with a one-word output holding register,
// valid/ready handoff, frame alignment and a sticky overrun flag.
module demux_1to4_deser (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic in_valid,
    input  logic frame_sync,
    input  logic out_ready,
    output logic O_0,
    output logic O_1,
    output logic O_2,
    output logic O_3,
    output logic out_valid,
    output logic S1,
    output logic S0,
    output logic overrun
);

    logic [1:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] word_q, word_d;
    logic       out_valid_q, out_valid_d;
    logic       overrun_q, overrun_d;
    logic [1:0] lane;
    logic       word_done;

    always_comb begin
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
        // frame_sync realigns before the incoming bit is placed
        lane        = frame_sync ? 2'd0 : cnt_q;

        if (in_valid) begin
            shadow_d[lane] = in_bit;
            cnt_d          = lane + 2'd1;
            word_done      = (lane == 2'd3);
        end else if (frame_sync) begin
            cnt_d = 2'd0;
        end

        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                word_d      = {in_bit, shadow_q[2:0]};
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 2'd0;
            shadow_q    <= 4'd0;
            word_q      <= 4'd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign O_0       = word_q[0];
    assign O_1       = word_q[1];
    assign O_2       = word_q[2];
    assign O_3       = word_q[3];
    assign out_valid = out_valid_q;
    assign {S1, S0}  = cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux_1to4_deser.sv
// Randomized + directed bench for demux_1to4_deser; the reference model tracks
// the bits of the word in progress as a queue and the output handoff as flags.
module tb_demux_1to4_deser;

    logic clk = 1'b0;
    logic reset, in_bit, in_valid, frame_sync, out_ready;
    logic O_0, O_1, O_2, O_3, out_valid, S1, S0, overrun;

    demux_1to4_deser dut (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .frame_sync(frame_sync), .out_ready(out_ready),
        .O_0(O_0), .O_1(O_1), .O_2(O_2), .O_3(O_3),
        .out_valid(out_valid), .S1(S1), .S0(S0), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference state
    bit       mq[$];
    bit [3:0] m_word;
    bit       m_vld, m_ovr;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit iv, input bit b, input bit fs, input bit rdy, input bit rst);
        bit       done;
        bit [3:0] w;
        done = 0;
        w    = '0;
        if (rst) begin
            mq.delete();
            m_word = '0;
            m_vld  = 0;
            m_ovr  = 0;
        end else begin
            if (fs) mq.delete();
            if (iv) begin
                mq.push_back(b);
                if (mq.size() == 4) begin
                    done = 1;
                    for (int i = 0; i < 4; i++) w[i] = mq[i];
                    mq.delete();
                end
            end
            if (done) begin
                if (!m_vld || rdy) begin
                    m_word = w;
                    m_vld  = 1;
                end else m_ovr = 1;
            end else if (m_vld && rdy) m_vld = 0;
        end
    endtask

    task automatic step(input bit iv, input bit b, input bit fs, input bit rdy, input bit rst);
        in_valid = iv; in_bit = b; frame_sync = fs; out_ready = rdy; reset = rst;
        @(posedge clk);
        model(iv, b, fs, rdy, rst);
        #1;
        chk("word", {O_3, O_2, O_1, O_0}, m_word);
        chk("out_valid", {3'b0, out_valid}, {3'b0, m_vld});
        chk("lane", {2'b0, S1, S0}, {2'b0, 2'(mq.size())});
        chk("overrun", {3'b0, overrun}, {3'b0, m_ovr});
    endtask

    task automatic send4(input bit [3:0] bits, input bit rdy);
        for (int i = 0; i < 4; i++) step(1, bits[i], 0, rdy, 0);
    endtask

    initial begin
        reset = 1; in_bit = 1; in_valid = 1; frame_sync = 1; out_ready = 1;
        #2;
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        chk("reset_word", {O_3, O_2, O_1, O_0}, 4'b0000);

        // bits 1,0,1,1 with consumer stalled
        send4(4'b1101, 0);
        chk("s026_word", {O_3, O_2, O_1, O_0}, 4'b1101);
        chk("s026_lane", {2'b0, S1, S0}, 4'd0);

        // gap in the middle of a word
        step(0, 0, 0, 1, 1);
        step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            chk("s027_hold", {2'b0, S1, S0}, 4'd2);
        end
        step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0);
        chk("s027_word", {O_3, O_2, O_1, O_0}, 4'b1011);

        // frame_sync together with a valid bit
        step(0, 0, 0, 1, 1);
        step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        chk("s028_lane", {2'b0, S1, S0}, 4'd1);
        step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0); step(1, 1, 0, 1, 0);
        chk("s028_word", {O_3, O_2, O_1, O_0}, 4'b1000);

        // overrun while first word is held
        step(0, 0, 0, 0, 1);
        send4(4'b0110, 0);
        send4(4'b1001, 0);
        chk("s029_ovr", {3'b0, overrun}, 4'd1);
        chk("s029_keep", {O_3, O_2, O_1, O_0}, 4'b0110);
        step(0, 0, 0, 1, 0);
        chk("s029_drain", {3'b0, out_valid}, 4'd0);
        chk("s029_sticky", {3'b0, overrun}, 4'd1);

        // consume and complete in the same cycle
        step(0, 0, 0, 0, 1);
        send4(4'b0011, 0);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        chk("s030_word", {O_3, O_2, O_1, O_0}, 4'b1010);
        chk("s030_vld", {3'b0, out_valid}, 4'd1);
        chk("s030_ovr", {3'b0, overrun}, 4'd0);

        // reset mid-word
        step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        send4(4'b0110, 0);
        chk("s031_word", {O_3, O_2, O_1, O_0}, 4'b0110);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0,
                 1'($urandom), $urandom_range(0, 99) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
